// File: rtl/descramble.sv
// 64b/66b self-synchronising descrambler (x^58+x^39+1); header error counter built with DESCRAMBLE_HDR_ERR_CNT_EN.
// Latency 2 cycles; no backpressure, every input cycle flows through and only valid words advance state.
module descramble (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [63:0] data_i,
  input  logic [1:0]  head_i,
  input  logic        data_vld_i,
  input  logic        block_lock_i,
  input  logic        hdr_err_cnt_clr_i,
  output logic [63:0] data_o,
  output logic [1:0]  head_o,
  output logic        data_vld_o,
  output logic        sync_o,
  output logic        hdr_err_o,
  output logic [15:0] hdr_err_cnt_o
);

  typedef enum logic {
    UNSYNC = 1'b0,
    SYNC   = 1'b1
  } sync_st_t;

  logic [63:0]  r_s1_data;
  logic [1:0]   r_s1_head;
  logic         r_s1_vld;
  logic         r_s1_lock;
  logic [57:0]  r_state;
  sync_st_t     r_sync_st;
  sync_st_t     w_sync_st_nxt;
  logic         w_sync_word;
  logic         w_s1_hdr_bad;
  logic [121:0] w_ext;
  logic [63:0]  w_descr;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_s1_data <= 64'h0;
      r_s1_head <= 2'b00;
      r_s1_vld  <= 1'b0;
      r_s1_lock <= 1'b0;
    end else begin
      r_s1_data <= data_i;
      r_s1_head <= head_i;
      r_s1_vld  <= data_vld_i;
      r_s1_lock <= block_lock_i;
    end
  end

  // w_ext[n+58] is line bit s(n); bits below 58 come from the previous valid word.
  assign w_ext   = {r_s1_data, r_state};
  assign w_descr = w_ext[121:58] ^ w_ext[82:19] ^ w_ext[63:0];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= 58'h0;
    end else if (r_s1_vld) begin
      r_state <= r_s1_data[63:6];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_sync_st <= UNSYNC;
    end else begin
      r_sync_st <= w_sync_st_nxt;
    end
  end

  always_comb begin
    w_sync_st_nxt = r_sync_st;
    w_sync_word   = 1'b0;
    case (r_sync_st)
      UNSYNC: begin
        if (r_s1_lock && r_s1_vld) begin
          w_sync_st_nxt = SYNC;
        end
      end
      SYNC: begin
        w_sync_word = r_s1_lock && r_s1_vld;
        if (!r_s1_lock) begin
          w_sync_st_nxt = UNSYNC;
        end
      end
      default: w_sync_st_nxt = UNSYNC;
    endcase
  end

  assign w_s1_hdr_bad = r_s1_vld && (r_s1_head[1] == r_s1_head[0]);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data_o     <= 64'h0;
      head_o     <= 2'b00;
      data_vld_o <= 1'b0;
      sync_o     <= 1'b0;
      hdr_err_o  <= 1'b0;
    end else begin
      data_o     <= w_descr;
      head_o     <= r_s1_head;
      data_vld_o <= r_s1_vld;
      sync_o     <= w_sync_word;
      hdr_err_o  <= w_s1_hdr_bad;
    end
  end

`ifdef DESCRAMBLE_HDR_ERR_CNT_EN
  logic [15:0] r_hdr_err_cnt;
  logic        w_hdr_inc;

  // Counted at the input so a clear and an error presented together land on the same edge.
  assign w_hdr_inc = data_vld_i && (head_i[1] == head_i[0]);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_hdr_err_cnt <= 16'h0;
    end else if (hdr_err_cnt_clr_i) begin
      r_hdr_err_cnt <= {15'h0, w_hdr_inc};
    end else if (w_hdr_inc && (r_hdr_err_cnt != 16'hFFFF)) begin
      r_hdr_err_cnt <= r_hdr_err_cnt + 16'd1;
    end
  end

  assign hdr_err_cnt_o = r_hdr_err_cnt;
`else
  logic w_unused_clr;

  assign w_unused_clr  = hdr_err_cnt_clr_i;
  assign hdr_err_cnt_o = 16'h0;
`endif

endmodule

// File: doc/descramble.md
DESCRAMBLE -- requirements
Module: descramble

Interface
REQ-001 SHALL have port clk_i, input, 1 bit: single clock, 156.25*2 MHz; all logic on its rising edge.
REQ-002 SHALL have port rst_i, input, 1 bit: reset, synchronous and active-high.
REQ-003 SHALL have port data_i, input, 64 bits: scrambled payload; bit 0 is first on the line.
REQ-004 SHALL have port head_i, input, 2 bits: sync header, never scrambled.
REQ-005 SHALL have port data_vld_i, input, 1 bit: word qualifier; only valid words advance the descrambler state.
REQ-006 SHALL have port block_lock_i, input, 1 bit: block lock from the gearbox/sync block.
REQ-007 SHALL have port hdr_err_cnt_clr_i, input, 1 bit: synchronous clear of the header error counter.
REQ-008 SHALL have port data_o, output, 64 bits: descrambled payload.
REQ-009 SHALL have port head_o, output, 2 bits: header, passed through unchanged.
REQ-010 SHALL have port data_vld_o, output, 1 bit: data_vld_i delayed by 2 cycles.
REQ-011 SHALL have port sync_o, output, 1 bit: high when data_o is produced from a fully populated state.
REQ-012 SHALL have port hdr_err_o, output, 1 bit: pulse when an invalid header (2'b00 or 2'b11) arrives on a valid word; aligned with data_vld_o.
REQ-013 SHALL have port hdr_err_cnt_o, output, 16 bits: saturating count of invalid headers.

Function
REQ-014 SHALL implement the self-synchronising descrambler for polynomial x^58+x^39+1: out[k] = s(k) ^ s(k-39) ^ s(k-58), k = 0..63.
REQ-015 SHALL take s(n) from current word bit n for n >= 0, and from bit 64+n of the most recent previous valid word for n < 0.
REQ-016 SHALL hold state as 58 bits equal to data_i[63:6] of the last valid word, loaded only when the word is valid; invalid words leave the state unchanged.
REQ-017 SHALL have a latency of exactly 2 cycles: input registered in stage 1, output registered in stage 2; data_o, head_o, data_vld_o, sync_o and hdr_err_o are all aligned.
REQ-018 SHALL still pass data_o and head_o through the pipeline on invalid cycles, with data_vld_o low.
REQ-019 SHALL implement a sync state machine with states UNSYNC and SYNC.
  - UNSYNC -> SYNC on the first valid word accepted while block_lock_i=1.
  - Any state -> UNSYNC whenever block_lock_i=0.
REQ-020 SHALL drive sync_o, per output word, to 1 only when the state was SYNC at the time that word was accepted; the first word after lock therefore outputs sync_o=0.
REQ-021 SHALL, while block_lock_i=0, still update the state on valid words, with sync_o=0.
REQ-022 SHALL treat hdr_err_o as evaluated on valid words only, regardless of block_lock_i.
REQ-023 SHALL make hdr_err_cnt_o saturate at 16'hFFFF.
REQ-024 SHALL, on a clear and an increment in the same cycle, give hdr_err_cnt_o = 1.

Reset
REQ-025 SHALL, while rst_i=1, clear the descrambler state, both pipeline stages and the counter, and force the FSM to UNSYNC.
REQ-026 SHALL hold all outputs at 0 while rst_i=1 and during the first 2 cycles after rst_i falls.
REQ-027 SHALL discard in-flight words on a mid-stream reset; the first valid word after reset yields sync_o=0.

Configuration
REQ-028 SHALL build the header error counter only when macro DESCRAMBLE_HDR_ERR_CNT_EN is defined.
REQ-029 SHALL, when DESCRAMBLE_HDR_ERR_CNT_EN is undefined, drive hdr_err_cnt_o to constant 16'h0, ignore hdr_err_cnt_clr_i, and remove the counter logic; hdr_err_o remains in both builds.

Verification
REQ-030 SHALL cover round trip: scramble module (state 58'h3) fed all-zero data, head 2'b01, continuous valid, output into descramble with lock=1 -> from the 2nd output word, data_o=64'h0, head_o=2'b01, sync_o=1.
REQ-031 SHALL cover error multiplication: flip data_i bit 0 of one word in a locked stream -> that output word differs from expected in exactly bits 0, 39 and 58; the next word is error-free.
REQ-032 SHALL cover valid gaps: insert 3 invalid cycles carrying random data between valid words -> every valid output word still matches the scrambler input, with data_vld_o low for 3 cycles.
REQ-033 SHALL cover lock loss: drop block_lock_i for 1 cycle mid-stream -> sync_o=0 on the word accepted in that cycle and on the next valid word, then 1.
REQ-034 SHALL cover header errors (macro defined): headers 2'b11, 2'b00, 2'b11 on valid words -> 3 hdr_err_o pulses, hdr_err_cnt_o=3; clear in the same cycle as a 4th error -> 1; preload to 16'hFFFF plus one error -> 16'hFFFF.
REQ-035 SHALL cover reset: assert rst_i for 1 cycle mid-stream -> all outputs 0 for 3 cycles; first valid output word after reset has sync_o=0.
